// File: rtl/spi_cmd_sched.sv
// Command scheduler sharing one x1spi engine between two descriptor requesters.
// It adds a Write Enable before write-class commands and watchdogs each engine transaction.
module spi_cmd_sched #(
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter logic [7:0]  WREN_CMD    = 8'h06
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_a_vld,
  input  logic [53:0] i_a_desc,
  input  logic [7:0]  i_a_wdata,
  output logic        o_a_done,
  input  logic        i_b_vld,
  input  logic [53:0] i_b_desc,
  input  logic [7:0]  i_b_wdata,
  output logic        o_b_done,
  output logic        o_err,
  output logic [1:0]  o_grant,
  output logic        o_busy,
  output logic        o_spi_start,
  output logic [53:0] o_spi_desc,
  output logic [7:0]  o_spi_wdata,
  input  logic        i_spi_rdy
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC);
  // The counter stops one short of TIMEOUT_CYC-1; the transition edge itself is the last cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARB       = 3'd1,
    WREN_GO   = 3'd2,
    WREN_WAIT = 3'd3,
    CMD_GO    = 3'd4,
    CMD_WAIT  = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t        state, state_nxt;
  logic          rr;
  logic [53:0]   desc_q;
  logic          busy_seen;
  logic [CW-1:0] tcnt;
  logic          err_q;

  logic          any_vld;
  logic          pick_b;
  logic [53:0]   pick_desc;
  logic          wait_exit;
  logic          wait_tmo;

  assign any_vld   = i_a_vld | i_b_vld;
  assign pick_b    = rr ? i_b_vld : ~i_a_vld;
  assign pick_desc = pick_b ? i_b_desc : i_a_desc;
  assign wait_exit = busy_seen & i_spi_rdy;
  assign wait_tmo  = (tcnt == CNT_LAST);

  always_comb begin
    o_spi_wdata = '0;
    if (o_grant[0])      o_spi_wdata = i_a_wdata;
    else if (o_grant[1]) o_spi_wdata = i_b_wdata;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (any_vld) state_nxt = ARB;
      ARB: begin
        if (!any_vld)          state_nxt = IDLE;
        else if (pick_desc[53]) state_nxt = WREN_GO;
        else                   state_nxt = CMD_GO;
      end
      WREN_GO:   state_nxt = WREN_WAIT;
      WREN_WAIT: begin
        if (wait_exit)     state_nxt = CMD_GO;
        else if (wait_tmo) state_nxt = DONE;
      end
      CMD_GO:    state_nxt = CMD_WAIT;
      CMD_WAIT:  if (wait_exit || wait_tmo) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      rr          <= 1'b0;
      desc_q      <= '0;
      busy_seen   <= 1'b0;
      tcnt        <= '0;
      err_q       <= 1'b0;
      o_a_done    <= 1'b0;
      o_b_done    <= 1'b0;
      o_err       <= 1'b0;
      o_grant     <= '0;
      o_busy      <= 1'b0;
      o_spi_start <= 1'b0;
      o_spi_desc  <= '0;
    end else begin
      state       <= state_nxt;
      o_busy      <= (state_nxt != IDLE);
      o_spi_start <= 1'b0;
      o_a_done    <= 1'b0;
      o_b_done    <= 1'b0;
      o_err       <= 1'b0;
      case (state)
        ARB: begin
          if (any_vld) begin
            desc_q  <= pick_desc;
            o_grant <= pick_b ? 2'b10 : 2'b01;
            err_q   <= 1'b0;
          end
        end
        WREN_GO: begin
          o_spi_desc  <= {46'd0, WREN_CMD};
          o_spi_start <= 1'b1;
          busy_seen   <= 1'b0;
          tcnt        <= '0;
        end
        CMD_GO: begin
          o_spi_desc  <= desc_q;
          o_spi_start <= 1'b1;
          busy_seen   <= 1'b0;
          tcnt        <= '0;
        end
        WREN_WAIT, CMD_WAIT: begin
          if (!i_spi_rdy) busy_seen <= 1'b1;
          if (wait_tmo) begin
            if (!wait_exit) err_q <= 1'b1;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        DONE: begin
          o_a_done <= o_grant[0];
          o_b_done <= o_grant[1];
          o_err    <= err_q;
          rr       <= o_grant[0];
          o_grant  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_sched.sv
// Directed bench for spi_cmd_sched: a long-timeout instance for normal traffic and
// a TIMEOUT_CYC=16 instance for watchdog cases, sharing clock, reset and engine model.
module tb_spi_cmd_sched;

  logic        clk;
  logic        rst_n;
  logic        a_vld, b_vld, t_a_vld, t_b_vld;
  logic [53:0] a_desc, b_desc;
  logic [7:0]  a_wdata, b_wdata;
  logic        rdy;

  logic        m_a_done, m_b_done, m_err, m_busy, m_spi_start;
  logic [1:0]  m_grant;
  logic [53:0] m_spi_desc;
  logic [7:0]  m_spi_wdata;
  logic        t_a_done, t_b_done, t_err, t_busy, t_spi_start;
  logic [1:0]  t_grant;
  logic [53:0] t_spi_desc;
  logic [7:0]  t_spi_wdata;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned m_start_n = 0;
  int unsigned t_start_n = 0;
  int unsigned wd_n = 0;
  int unsigned wd_bad = 0;
  int unsigned err_stray = 0;
  int unsigned eng_len = 0;

  spi_cmd_sched #(.TIMEOUT_CYC(1000), .WREN_CMD(8'h06)) u_m (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_vld(a_vld), .i_a_desc(a_desc), .i_a_wdata(a_wdata), .o_a_done(m_a_done),
    .i_b_vld(b_vld), .i_b_desc(b_desc), .i_b_wdata(b_wdata), .o_b_done(m_b_done),
    .o_err(m_err), .o_grant(m_grant), .o_busy(m_busy), .o_spi_start(m_spi_start),
    .o_spi_desc(m_spi_desc), .o_spi_wdata(m_spi_wdata), .i_spi_rdy(rdy)
  );

  spi_cmd_sched #(.TIMEOUT_CYC(16), .WREN_CMD(8'h06)) u_t (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_vld(t_a_vld), .i_a_desc(a_desc), .i_a_wdata(a_wdata), .o_a_done(t_a_done),
    .i_b_vld(t_b_vld), .i_b_desc(b_desc), .i_b_wdata(b_wdata), .o_b_done(t_b_done),
    .o_err(t_err), .o_grant(t_grant), .o_busy(t_busy), .o_spi_start(t_spi_start),
    .o_spi_desc(t_spi_desc), .o_spi_wdata(t_spi_wdata), .i_spi_rdy(rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [53:0] mk_desc(input logic [7:0] cmd, input logic [23:0] addr,
                                          input logic exa, input logic [2:0] dum,
                                          input logic exd, input logic [15:0] dn,
                                          input logic wr);
    return {wr, dn, exd, dum, exa, addr, cmd};
  endfunction

  task automatic wait_start(input bit tmo, input int unsigned limit, output int unsigned n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tmo ? t_spi_start : m_spi_start) && n < limit);
    if (!(tmo ? t_spi_start : m_spi_start)) check("start_wait_expired", 1'b0, 1'b1);
  endtask

  task automatic wait_done(input bit tmo, input int unsigned limit, output int unsigned n);
    logic d;
    n = 0;
    d = 1'b0;
    while (!d && n < limit) begin
      @(negedge clk);
      n++;
      d = tmo ? (t_a_done | t_b_done) : (m_a_done | m_b_done);
    end
    if (!d) check("done_wait_expired", 1'b0, 1'b1);
  endtask

  // Engine model: goes busy one cycle after a start and stays busy eng_len cycles.
  initial begin
    rdy = 1'b1;
    forever begin
      @(negedge clk);
      if ((m_spi_start || t_spi_start) && eng_len != 0) begin
        @(negedge clk);
        rdy = 1'b0;
        repeat (eng_len) @(negedge clk);
        rdy = 1'b1;
      end
    end
  end

  // Start counting, write-data tracking, stray error detection, wdata stimulus.
  initial begin
    a_wdata = 8'h11;
    b_wdata = 8'h80;
    forever begin
      @(negedge clk);
      if (m_spi_start) m_start_n++;
      if (t_spi_start) t_start_n++;
      if (m_grant == 2'b10) begin
        wd_n++;
        if (m_spi_wdata !== b_wdata) wd_bad++;
      end else if (m_grant == 2'b01) begin
        if (m_spi_wdata !== a_wdata) wd_bad++;
      end else if (m_spi_wdata !== 8'h00) begin
        wd_bad++;
      end
      if (m_err && !(m_a_done || m_b_done)) err_stray++;
      if (t_err && !(t_a_done || t_b_done)) err_stray++;
      b_wdata = b_wdata + 8'h1F;
      a_wdata = a_wdata ^ 8'h5A;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [53:0] rd_a, rd_a2, rd_b, wr_b, wren_exp;
    logic [1:0]  eg;
    int unsigned n, base;

    rd_a     = mk_desc(8'h03, 24'h3F0000, 1'b1, 3'd0, 1'b1, 16'd8, 1'b0);
    rd_a2    = mk_desc(8'h0B, 24'h001234, 1'b1, 3'd1, 1'b1, 16'd2, 1'b0);
    rd_b     = mk_desc(8'h05, 24'h000000, 1'b0, 3'd0, 1'b1, 16'd1, 1'b0);
    wr_b     = mk_desc(8'h02, 24'h001000, 1'b1, 3'd0, 1'b1, 16'd4, 1'b1);
    wren_exp = mk_desc(8'h06, 24'h000000, 1'b0, 3'd0, 1'b0, 16'd0, 1'b0);

    a_vld = 1'b0; b_vld = 1'b0; t_a_vld = 1'b0; t_b_vld = 1'b0;
    a_desc = '0; b_desc = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", m_busy, 1'b0);
    check("rst_grant", m_grant, 2'b00);
    check("rst_start", m_spi_start, 1'b0);
    check("rst_desc", m_spi_desc, 54'd0);
    check("rst_wdata", m_spi_wdata, 8'h00);
    check("rst_done", {m_a_done, m_b_done}, 2'b00);
    check("rst_err", m_err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Read on A
    eng_len = 20;
    a_desc = rd_a;
    base = m_start_n;
    a_vld = 1'b1;
    wait_start(0, 10, n);
    check("rd_start_lat", n, 3);
    check("rd_desc", m_spi_desc, rd_a);
    check("rd_grant", m_grant, 2'b01);
    wait_done(0, 40, n);
    check("rd_done_lat", n, 23);
    check("rd_a_done", m_a_done, 1'b1);
    check("rd_b_done", m_b_done, 1'b0);
    check("rd_err", m_err, 1'b0);
    a_vld = 1'b0;
    repeat (3) @(negedge clk);
    check("rd_start_count", m_start_n - base, 1);
    check("rd_idle_busy", m_busy, 1'b0);

    // Reset in the middle of CMD_WAIT, then rr must favour A again
    eng_len = 30;
    a_vld = 1'b1;
    wait_start(0, 10, n);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    a_vld = 1'b0;
    #1;
    check("mid_rst_busy", m_busy, 1'b0);
    check("mid_rst_grant", m_grant, 2'b00);
    check("mid_rst_start", m_spi_start, 1'b0);
    n = 0;
    while (!rdy && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    eng_len = 6;
    a_desc = rd_a2;
    b_desc = rd_b;
    a_vld = 1'b1;
    b_vld = 1'b1;
    wait_start(0, 10, n);
    check("post_rst_start_lat", n, 3);
    check("post_rst_grant", m_grant, 2'b01);
    check("post_rst_desc", m_spi_desc, rd_a2);
    b_vld = 1'b0;
    wait_done(0, 30, n);
    check("post_rst_done_lat", n, 9);
    check("post_rst_a_done", m_a_done, 1'b1);
    check("post_rst_err", m_err, 1'b0);
    a_vld = 1'b0;
    repeat (3) @(negedge clk);

    // Write on B with automatic WREN prefix
    eng_len = 5;
    b_desc = wr_b;
    base = m_start_n;
    wd_n = 0;
    wd_bad = 0;
    b_vld = 1'b1;
    wait_start(0, 10, n);
    check("wr_wren_lat", n, 3);
    check("wr_wren_desc", m_spi_desc, wren_exp);
    check("wr_wren_grant", m_grant, 2'b10);
    wait_start(0, 20, n);
    check("wr_cmd_lat", n, 8);
    check("wr_cmd_desc", m_spi_desc, wr_b);
    wait_done(0, 20, n);
    check("wr_done_lat", n, 8);
    check("wr_b_done", m_b_done, 1'b1);
    check("wr_a_done", m_a_done, 1'b0);
    check("wr_err", m_err, 1'b0);
    b_vld = 1'b0;
    repeat (3) @(negedge clk);
    check("wr_start_count", m_start_n - base, 2);
    check("wr_wdata_mismatches", wd_bad, 0);
    check("wr_wdata_sampled", (wd_n >= 15), 1'b1);

    // Contention after reset: strict A,B,A,B alternation
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    eng_len = 3;
    a_desc = rd_a;
    b_desc = rd_b;
    a_vld = 1'b1;
    b_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
      wait_start(0, 20, n);
      check($sformatf("cont_grant_%0d", i), m_grant, eg);
      wait_done(0, 20, n);
      check($sformatf("cont_done_%0d", i), {m_b_done, m_a_done}, eg);
    end
    a_vld = 1'b0;
    b_vld = 1'b0;
    repeat (3) @(negedge clk);

    // Command timeout: engine never goes busy
    eng_len = 0;
    a_desc = rd_a;
    base = t_start_n;
    t_a_vld = 1'b1;
    wait_start(1, 10, n);
    check("tmo_start_lat", n, 3);
    wait_done(1, 40, n);
    check("tmo_done_lat", n, 16);
    check("tmo_a_done", t_a_done, 1'b1);
    check("tmo_err", t_err, 1'b1);
    t_a_vld = 1'b0;
    repeat (4) @(negedge clk);
    check("tmo_start_count", t_start_n - base, 1);

    // WREN timeout: main command must be skipped
    a_desc = wr_b;
    base = t_start_n;
    t_a_vld = 1'b1;
    wait_start(1, 10, n);
    check("wtmo_wren_desc", t_spi_desc, wren_exp);
    wait_done(1, 40, n);
    check("wtmo_done_lat", n, 16);
    check("wtmo_err", t_err, 1'b1);
    t_a_vld = 1'b0;
    repeat (20) @(negedge clk);
    check("wtmo_start_count", t_start_n - base, 1);
    check("wtmo_idle_busy", t_busy, 1'b0);

    check("stray_err", err_stray, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_sched.md
# spi_cmd_sched

Command scheduler in front of the x1spi flash engine. Shares the single engine between two descriptor requesters: port A (UART command path, fed by address translation) and port B (local maintenance/boot requester). Automatically prefixes every write-class command with a Write Enable (0x06), and supervises each engine transaction with a busy-handshake and a timeout.

## Interface
Parameters:
- TIMEOUT_CYC, 1000000: cycles allowed per engine transaction (start to ready), must be ≥ 4
- WREN_CMD, 8'h06: opcode issued before write-class commands

Descriptor layout (54 bits, used for `i_a_desc`, `i_b_desc`, `o_spi_desc`):
- [7:0] cmd
- [31:8] addr
- [32] exi_addr
- [35:33] dum_num
- [36] exi_data
- [52:37] data_num
- [53] wr_en

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_a_vld  in  1  port A request; level, held with stable descriptor until o_a_done
- i_a_desc  in  54  port A descriptor
- i_a_wdata  in  8  port A write byte stream
- o_a_done  out  1  one-cycle completion pulse for A
- i_b_vld / i_b_desc / i_b_wdata / o_b_done: same as A for port B
- o_err  out  1  valid with a done pulse; 1 = timeout
- o_grant  out  2  one-hot owner ({B,A}), 0 when idle
- o_busy  out  1  high in every state except IDLE
- o_spi_start  out  1  one-cycle start pulse to engine
- o_spi_desc  out  54  registered descriptor to engine
- o_spi_wdata  out  8  granted port's wdata (combinational mux), 0 when no grant
- i_spi_rdy  in  1  engine idle/ready

## Operation
- States: IDLE, ARB, WREN_GO, WREN_WAIT, CMD_GO, CMD_WAIT, DONE.
- IDLE: if either vld is high, go to ARB.
- ARB: choose the winner by round-robin pointer `rr` (0 favours A, 1 favours B), latch its descriptor, and set o_grant. If the latched wr_en=1, go to WREN_GO; otherwise go to CMD_GO.
- WREN_GO: o_spi_desc = {wr_en=0, data_num=0, exi_data=0, dum_num=0, exi_addr=0, addr=0, cmd=WREN_CMD}, o_spi_start=1 for one cycle. Clear busy_seen and the timeout counter, then go to WREN_WAIT.
- WREN_WAIT / CMD_WAIT:
  - Set busy_seen when i_spi_rdy=0.
  - Exit when busy_seen=1 and i_spi_rdy=1: WREN_WAIT goes to CMD_GO; CMD_WAIT goes to DONE with err=0.
  - Timeout counter increments every cycle. At TIMEOUT_CYC-1, go to DONE with err=1; the main command is skipped after a WREN timeout.
- CMD_GO: o_spi_desc = latched descriptor verbatim (wr_en passes through), o_spi_start=1 for one cycle. Clear busy_seen and the counter, then go to CMD_WAIT.
- DONE:
  - Pulse the granted port's done with o_err.
  - Set rr to the non-granted port.
  - Clear o_grant and go to IDLE.
- Requester dropping vld mid-transaction is ignored: the transaction completes and done still pulses.
- o_spi_desc holds its last value between transactions.
- Timeout counter width is clog2(TIMEOUT_CYC) and the counter never wraps.

## Timing
- Reset (async, immediate):
  - State=IDLE, rr=0.
  - o_a_done, o_b_done, o_err, o_busy, o_spi_start = 0.
  - o_grant=0, o_spi_desc=0, o_spi_wdata=0.
- All outputs are registered except o_spi_wdata.
- vld sampled high at edge k (IDLE):
  - ARB at k+1.
  - o_grant valid and o_spi_start high in cycle k+2 to k+3 (write: WREN start; read: command start).
- Minimum read transaction: engine drops rdy the cycle after start and raises it n cycles later. done pulses 2 cycles after the rdy rising edge is sampled.
- Write adds one full WREN round trip plus 1 cycle before the command start.
- Simultaneous vld in IDLE: the rr pointer decides. A request arriving while busy waits; it is granted in ARB immediately after the current DONE→IDLE.
- Back-to-back: same port re-requesting loses to a pending other port (rr alternation).
- o_err is 0 whenever no done pulse is present.

## Test plan
- Read, A only: desc cmd=0x03, addr=0x3F0000, wr_en=0; engine rdy low 1 cycle after start, high 20 cycles later. Required:
  - exactly one o_spi_start.
  - o_spi_desc equals the descriptor.
  - o_a_done=1 and o_err=0 two cycles after rdy rises.
- Write, B only: desc cmd=0x02, wr_en=1, data_num=4. Required:
  - first start carries cmd=0x06 with all other fields 0.
  - second start carries cmd=0x02 with wr_en=1.
  - o_spi_wdata tracks i_b_wdata while o_grant=2'b10.
  - a single o_b_done.
- Contention: A and B both vld at the same edge after reset, each re-requesting immediately after done. Required: grant order A,B,A,B over 4 transactions.
- Timeout: TIMEOUT_CYC=16, rdy held 1 (never falls) after start. Required: o_a_done=1 with o_err=1 exactly 16 cycles after the start cycle, and no second start.
- WREN timeout: wr_en=1, engine never goes busy on WREN. Required: done with err=1, and the main command is never started.
- Async reset mid-CMD_WAIT: assert i_rst_n=0 between edges. Required:
  - o_busy, o_grant, o_spi_start = 0 immediately.
  - after release, a new A read completes normally with rr=0.
